// File: rtl/soc_ifc_fw_upd_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : soc_ifc_fw_upd_rst_ctrl
//  Description : Firmware-update-reset sequencer. Arbitrates requests from
//                several sources, quiesces the uC, drives fw_update_rst into
//                the boot FSM and reports per-requester completion, timeout
//                errors and a saturating execution count.
//  Revision    : 1.0 - initial release
// ============================================================================

package soc_ifc_fw_upd_rst_ctrl_pkg;
    typedef enum logic [2:0] {
        BOOT_IDLE   = 3'b000,
        BOOT_FUSE   = 3'b001,
        BOOT_FW_RST = 3'b010,
        BOOT_WAIT   = 3'b011,
        BOOT_DONE   = 3'b100
    } boot_fsm_state_e;
endpackage

module soc_ifc_fw_upd_rst_ctrl
    import soc_ifc_fw_upd_rst_ctrl_pkg::*;
#(
    parameter int         NUM_REQ  = 2,
    parameter logic [7:0] MIN_WAIT = 8'd1
) (
    input  logic                       clk,
    input  logic                       cptra_noncore_rst_b,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [7:0]                 wait_cycles_cfg,
    input  logic [15:0]                timeout_cfg,
    input  boot_fsm_state_e            boot_fsm_ps,
    input  logic                       uc_quiesce_ack,
    input  logic                       err_clr,
    output logic                       fw_update_rst,
    output logic [7:0]                 fw_update_rst_wait_cycles,
    output logic                       uc_quiesce_req,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err_timeout,
    output logic [7:0]                 upd_count
);

    localparam int c_GW = $clog2(NUM_REQ);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_QUIESCE   = 3'd1;
    localparam logic [2:0] c_ST_ASSERT    = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ST_COMPLETE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [NUM_REQ-1:0] r_pending;
    logic [c_GW-1:0]    r_rr_ptr;
    logic [c_GW-1:0]    r_grant_id;
    logic [c_GW-1:0]    w_grant;
    logic               w_found;
    logic               w_grant_now;
    logic [NUM_REQ-1:0] w_clr_mask;
    logic [NUM_REQ-1:0] w_done_mask;
    logic [15:0]        r_tmo_cnt;
    logic               w_exit;
    logic               w_in_phase;
    logic               w_nxt_in_phase;
    logic               w_tmo_fire;
    logic               w_abort;
    logic               w_complete;
    logic               r_fw_update_rst;
    logic [7:0]         r_wait_cycles;
    logic               r_uc_quiesce_req;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err_timeout;
    logic [7:0]         r_upd_count;

    // Round-robin pick: lowest pending index at or after rr_ptr, else wrap to lowest pending.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r_pending[i] && (i >= int'(r_rr_ptr))) begin
                w_found = 1'b1;
                w_grant = c_GW'(i);
            end
        end
        if (!w_found) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (r_pending[i]) begin
                    w_found = 1'b1;
                    w_grant = c_GW'(i);
                end
            end
        end
    end

    // Normal exit condition of the phase currently being executed.
    always_comb begin
        w_exit = 1'b0;
        case (r_state)
            c_ST_QUIESCE:   w_exit = uc_quiesce_ack;
            c_ST_ASSERT:    w_exit = (boot_fsm_ps == BOOT_FW_RST) || (boot_fsm_ps == BOOT_WAIT);
            c_ST_WAIT_DONE: w_exit = (boot_fsm_ps == BOOT_DONE);
            default:        w_exit = 1'b0;
        endcase
    end

    assign w_in_phase = (r_state == c_ST_QUIESCE) || (r_state == c_ST_ASSERT) ||
                        (r_state == c_ST_WAIT_DONE);
    // A warm reset of the boot FSM cancels any sequence in flight, silently.
    assign w_abort    = (r_state != c_ST_IDLE) &&
                        ((boot_fsm_ps == BOOT_IDLE) || (boot_fsm_ps == BOOT_FUSE));
    // A counter loaded with 0 never reads 1, so timeout_cfg == 0 disables the timeout.
    assign w_tmo_fire = w_in_phase && (r_tmo_cnt == 16'd1) && !w_exit && !w_abort;
    assign w_complete = (r_state == c_ST_COMPLETE) && !w_abort;

    // Next-state selection; abort overrides everything, exit wins over timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found && (boot_fsm_ps == BOOT_DONE)) w_state_nxt = c_ST_QUIESCE;
                end
                c_ST_QUIESCE: begin
                    // A quiesce timeout still forces the reset through.
                    if (w_exit || w_tmo_fire) w_state_nxt = c_ST_ASSERT;
                end
                c_ST_ASSERT: begin
                    if (w_exit)          w_state_nxt = c_ST_WAIT_DONE;
                    else if (w_tmo_fire) w_state_nxt = c_ST_IDLE;
                end
                c_ST_WAIT_DONE: begin
                    if (w_exit)          w_state_nxt = c_ST_COMPLETE;
                    else if (w_tmo_fire) w_state_nxt = c_ST_IDLE;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    assign w_grant_now    = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_QUIESCE);
    assign w_nxt_in_phase = (w_state_nxt == c_ST_QUIESCE) || (w_state_nxt == c_ST_ASSERT) ||
                            (w_state_nxt == c_ST_WAIT_DONE);

    // One-hot masks for clearing the granted pending bit and for the done pulse.
    always_comb begin
        w_clr_mask  = '0;
        w_done_mask = '0;
        if (w_grant_now) w_clr_mask[w_grant] = 1'b1;
        w_done_mask[r_grant_id] = 1'b1;
    end

    // Sequencer state, pending/arbitration bookkeeping, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge cptra_noncore_rst_b) begin
        if (!cptra_noncore_rst_b) begin
            r_state          <= c_ST_IDLE;
            r_pending        <= '0;
            r_rr_ptr         <= '0;
            r_grant_id       <= '0;
            r_tmo_cnt        <= 16'd0;
            r_fw_update_rst  <= 1'b0;
            r_wait_cycles    <= MIN_WAIT;
            r_uc_quiesce_req <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= '0;
            r_err_timeout    <= 1'b0;
            r_upd_count      <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            // New pulses OR in after the grant clear, so a request that lands
            // during its own service is run again afterwards.
            r_pending <= (r_pending & ~w_clr_mask) | req;

            if (w_grant_now) begin
                r_grant_id    <= w_grant;
                r_rr_ptr      <= (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;
                r_wait_cycles <= (wait_cycles_cfg < MIN_WAIT) ? MIN_WAIT : wait_cycles_cfg;
            end

            if ((w_state_nxt != r_state) && w_nxt_in_phase) begin
                r_tmo_cnt <= timeout_cfg;
            end else if (r_tmo_cnt != 16'd0) begin
                r_tmo_cnt <= r_tmo_cnt - 16'd1;
            end

            // Control outputs follow the present state one cycle later.
            r_fw_update_rst  <= (r_state == c_ST_ASSERT);
            r_uc_quiesce_req <= (r_state == c_ST_QUIESCE) || (r_state == c_ST_ASSERT);
            r_busy           <= (r_state != c_ST_IDLE);
            r_done           <= w_complete ? w_done_mask : '0;

            if (w_complete && (r_upd_count != 8'hFF)) begin
                r_upd_count <= r_upd_count + 8'd1;
            end

            // Set has priority over clear.
            if (w_tmo_fire) begin
                r_err_timeout <= 1'b1;
            end else if (err_clr) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    assign fw_update_rst             = r_fw_update_rst;
    assign fw_update_rst_wait_cycles = r_wait_cycles;
    assign uc_quiesce_req            = r_uc_quiesce_req;
    assign busy                      = r_busy;
    assign grant_id                  = r_grant_id;
    assign done                      = r_done;
    assign err_timeout               = r_err_timeout;
    assign upd_count                 = r_upd_count;

endmodule

`default_nettype wire
